// File: rtl/seg_decode_monitor.sv
// Seven-segment glyph monitor: synchronizes an asynchronous segment bus,
// waits for the pattern to settle, decodes each newly settled glyph to a hex
// digit (flagging illegal patterns) and buffers the results in a small FIFO.
module seg_decode_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [6:0]                       seg_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [3:0]                       out_digit,
  output logic                             out_err,
  output logic                             overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0]    STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0]    STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

  logic [6:0]    sync_meta;
  logic [6:0]    s;
  logic [6:0]    prev_s;
  logic [7:0]    cnt;
  logic [6:0]    last_committed;
  logic          commit;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic [3:0]    dec_digit;
  logic          dec_err;
  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;

  // Two-flop synchronizer bringing the asynchronous segment bus into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 7'h00;
      s         <= 7'h00;
    end else begin
      sync_meta <= seg_in;
      s         <= sync_meta;
    end
  end

  // A commit fires only on the cycle the stability count reaches its limit,
  // so a glyph held indefinitely is accepted exactly once.
  assign commit = (s == prev_s) && (cnt == STABLE_LAST) && (s != last_committed);
  assign push   = commit && (s != 7'h00);

  // Stability tracking and remembering the most recently accepted pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_s         <= 7'h00;
      cnt            <= 8'd0;
      last_committed <= 7'h00;
    end else begin
      prev_s <= s;
      if (s != prev_s) begin
        cnt <= 8'd0;
      end else if (cnt != STABLE_MAX) begin
        cnt <= cnt + 8'd1;
      end
      if (commit) begin
        last_committed <= s;
      end
    end
  end

  // Segment pattern {g,f,e,d,c,b,a} to hex digit; unknown shapes flag err.
  always_comb begin
    dec_digit = 4'h0;
    dec_err   = 1'b0;
    case (s)
      7'h3F: dec_digit = 4'h0;
      7'h06: dec_digit = 4'h1;
      7'h5B: dec_digit = 4'h2;
      7'h4F: dec_digit = 4'h3;
      7'h66: dec_digit = 4'h4;
      7'h6D: dec_digit = 4'h5;
      7'h7D: dec_digit = 4'h6;
      7'h07: dec_digit = 4'h7;
      7'h7F: dec_digit = 4'h8;
      7'h6F: dec_digit = 4'h9;
      7'h77: dec_digit = 4'hA;
      7'h7C: dec_digit = 4'hB;
      7'h39: dec_digit = 4'hC;
      7'h5E: dec_digit = 4'hD;
      7'h79: dec_digit = 4'hE;
      7'h71: dec_digit = 4'hF;
      default: begin
        dec_digit = 4'h0;
        dec_err   = 1'b1;
      end
    endcase
  end

  assign full    = (count == DEPTH_C);
  assign pop     = out_valid && out_ready;
  assign push_ok = push && (!full || pop);

  // Output FIFO; a simultaneous pop frees the slot so a push into a full FIFO
  // is still accepted, otherwise a push into a full FIFO is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 5'h00;
      end
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      if (push_ok) begin
        mem[wptr] <= {dec_err, dec_digit};
        wptr      <= wptr + AW'(1);
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
      if (push_ok && !pop) begin
        count <= count + CW'(1);
      end else if (!push_ok && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  assign out_valid  = (count != '0);
  assign out_digit  = mem[rptr][3:0];
  assign out_err    = mem[rptr][4];
  assign fifo_count = count;

endmodule
